// File: rtl/systolic_mm_engine_if.sv
// Job/result handshake bundle for systolic_mm_engine.
// master: job producer / result consumer; slave: the engine.
interface systolic_mm_engine_if #(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    signed_mode;
   logic [N*N*DATA_W-1:0]   a_mat;
   logic [N*N*DATA_W-1:0]   b_mat;
   logic [N*N*ACC_W-1:0]    c_mat;
   logic                    out_valid;
   logic                    out_ready;
   logic                    ovf;

   modport master (
      output in_valid, signed_mode, a_mat, b_mat, out_ready,
      input  in_ready, c_mat, out_valid, ovf
   );

   modport slave (
      input  in_valid, signed_mode, a_mat, b_mat, out_ready,
      output in_ready, c_mat, out_valid, ovf
   );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary NxN systolic matrix multiplier, C = A x B.
// A job is latched whole on accept; rows of A enter from the left and
// columns of B from the top, each skewed by its row/column index.
// PEs multiply their registered operands, so COMPUTE runs the 3N-2
// injection steps plus one drain step before the result is presented.
// Optional build macro SYSTOLIC_SAT_EN: saturating accumulators and a
// sticky ovf flag; without it accumulators wrap and ovf is tied low.
module systolic_mm_engine #(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
) (
   input  logic               clk,
   input  logic               reset,
   systolic_mm_engine_if.slave bus
);

   localparam int KW = $clog2(3 * N);
   localparam int PW = 2 * DATA_W;
   localparam logic [KW-1:0] K_LAST = KW'(3 * N - 2);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COMPUTE = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   logic [1:0]            r_state;
   logic [KW-1:0]         r_k;
   logic [N*N*DATA_W-1:0] r_a_mat;
   logic [N*N*DATA_W-1:0] r_b_mat;
   logic                  r_signed;

   logic                  w_accept;
   logic                  w_compute;
   logic [DATA_W-1:0]     w_feed_a [N];
   logic [DATA_W-1:0]     w_feed_b [N];
   logic [DATA_W-1:0]     w_a_pipe [N][N];
   logic [DATA_W-1:0]     w_b_pipe [N][N];
   logic [N*N*ACC_W-1:0]  w_c_mat;

   assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
   assign w_compute = (r_state == S_COMPUTE);

   assign bus.in_ready  = (r_state == S_IDLE) && !reset;
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.c_mat     = w_c_mat;

   // Control FSM: latch the job on accept, step k through COMPUTE, hold DONE until consumed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_k      <= '0;
         r_a_mat  <= '0;
         r_b_mat  <= '0;
         r_signed <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a_mat  <= bus.a_mat;
                  r_b_mat  <= bus.b_mat;
                  r_signed <= bus.signed_mode;
                  r_k      <= '0;
                  r_state  <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               if (r_k == K_LAST) begin
                  r_state <= S_DONE;
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Skew feeders: row i injects A[i][k-i], column j injects B[k-j][j], zero outside the window
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_feed_a[i] = '0;
         w_feed_b[i] = '0;
         for (int m = 0; m < N; m++) begin
            if (w_compute && (r_k == KW'(i + m))) begin
               w_feed_a[i] = r_a_mat[(i*N + m)*DATA_W +: DATA_W];
               w_feed_b[i] = r_b_mat[(m*N + i)*DATA_W +: DATA_W];
            end
         end
      end
   end

`ifdef SYSTOLIC_SAT_EN
   logic [N*N-1:0] w_clamp;
   logic           r_ovf;

   // Sticky overflow: cleared with the accumulators, set by any PE clamp while computing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_ovf <= 1'b0;
      end else if (w_compute && (|w_clamp)) begin
         r_ovf <= 1'b1;
      end
   end

   assign bus.ovf = r_ovf;
`else
   assign bus.ovf = 1'b0;
`endif

   genvar gi, gj;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         for (gj = 0; gj < N; gj++) begin : g_col
            logic [DATA_W-1:0]    r_a;
            logic [DATA_W-1:0]    r_b;
            logic [ACC_W-1:0]     r_acc;
            logic [DATA_W-1:0]    w_a_in;
            logic [DATA_W-1:0]    w_b_in;
            logic [PW-1:0]        w_prod_u;
            logic signed [PW-1:0] w_prod_s;
            logic [ACC_W-1:0]     w_ext_u;
            logic [ACC_W-1:0]     w_ext_s;
            logic [ACC_W-1:0]     w_prod_ext;
            logic [ACC_W-1:0]     w_acc_next;

            if (gj == 0) begin : g_a_src
               assign w_a_in = w_feed_a[gi];
            end else begin : g_a_src
               assign w_a_in = w_a_pipe[gi][gj-1];
            end

            if (gi == 0) begin : g_b_src
               assign w_b_in = w_feed_b[gj];
            end else begin : g_b_src
               assign w_b_in = w_b_pipe[gi-1][gj];
            end

            assign w_prod_u   = PW'(r_a) * PW'(r_b);
            assign w_prod_s   = PW'($signed(r_a)) * PW'($signed(r_b));
            assign w_ext_u    = ACC_W'(w_prod_u);
            assign w_ext_s    = ACC_W'(w_prod_s);
            assign w_prod_ext = r_signed ? w_ext_s : w_ext_u;

`ifdef SYSTOLIC_SAT_EN
            logic [ACC_W:0] w_sum;
            logic           w_ovf;

            assign w_sum = {r_signed & r_acc[ACC_W-1], r_acc}
                         + {r_signed & w_prod_ext[ACC_W-1], w_prod_ext};

            // Clamp to the signed or unsigned range when the extra sum bit shows overflow
            always_comb begin
               w_acc_next = w_sum[ACC_W-1:0];
               w_ovf      = 1'b0;
               if (r_signed) begin
                  if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
                     w_ovf      = 1'b1;
                     w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                               : {1'b0, {(ACC_W-1){1'b1}}};
                  end
               end else if (w_sum[ACC_W]) begin
                  w_ovf      = 1'b1;
                  w_acc_next = '1;
               end
            end

            assign w_clamp[gi*N + gj] = w_ovf;
`else
            assign w_acc_next = r_acc + w_prod_ext;
`endif

            // PE: pass a right and b down, accumulate the product of the held operands
            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  r_a   <= '0;
                  r_b   <= '0;
                  r_acc <= '0;
               end else if (w_accept) begin
                  r_a   <= '0;
                  r_b   <= '0;
                  r_acc <= '0;
               end else if (w_compute) begin
                  r_a   <= w_a_in;
                  r_b   <= w_b_in;
                  r_acc <= w_acc_next;
               end
            end

            assign w_a_pipe[gi][gj]                      = r_a;
            assign w_b_pipe[gi][gj]                      = r_b;
            assign w_c_mat[(gi*N + gj)*ACC_W +: ACC_W]   = r_acc;
         end
      end
   endgenerate

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Scoreboard bench for systolic_mm_engine (N=4, DATA_W=8, ACC_W=20) plus
// a second ACC_W=16 instance for accumulator width limits.
module tb_systolic_mm_engine;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 20;
   localparam int CW = N * N * AW;
`ifdef SYSTOLIC_SAT_EN
   localparam bit SAT_ON = 1'b1;
`else
   localparam bit SAT_ON = 1'b0;
`endif

   logic clk;
   logic reset;
   int   cyc;
   int   n_checks;
   int   n_errors;
   int   n_out;
   logic prev_ov;

   logic [CW-1:0] exp_q [$];
   int            acc_log [$];
   int            hs_log [$];

   systolic_mm_engine_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) bus ();
   systolic_mm_engine_if #(.N(N), .DATA_W(DW), .ACC_W(16)) bus16 ();

   systolic_mm_engine #(.N(N), .DATA_W(DW), .ACC_W(AW)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   systolic_mm_engine #(.N(N), .DATA_W(DW), .ACC_W(16)) u_dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h", tag, act, exp);
      end
   endtask

   // Reference C = A x B with element width aw, optional per-step clamping
   function automatic logic [CW-1:0] mm_model(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b,
                                              input logic s, input int aw, input bit sat);
      logic [CW-1:0] r;
      longint acc, x, y, hi, lo;
      r = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            acc = 0;
            for (int m = 0; m < N; m++) begin
               if (s) begin
                  x = longint'($signed(a[(i*N+m)*DW +: DW]));
                  y = longint'($signed(b[(m*N+j)*DW +: DW]));
               end else begin
                  x = longint'(a[(i*N+m)*DW +: DW]);
                  y = longint'(b[(m*N+j)*DW +: DW]);
               end
               acc = acc + x * y;
               if (sat) begin
                  if (s) begin
                     hi = (longint'(1) <<< (aw - 1)) - 1;
                     lo = -(longint'(1) <<< (aw - 1));
                  end else begin
                     hi = (longint'(1) <<< aw) - 1;
                     lo = 0;
                  end
                  if (acc > hi) acc = hi;
                  if (acc < lo) acc = lo;
               end
            end
            for (int t = 0; t < aw; t++) r[(i*N+j)*aw + t] = acc[t];
         end
      end
      return r;
   endfunction

   function automatic logic [N*N*DW-1:0] fill_mat(input logic [DW-1:0] v);
      logic [N*N*DW-1:0] m;
      for (int k = 0; k < N*N; k++) m[k*DW +: DW] = v;
      return m;
   endfunction

   function automatic logic [N*N*DW-1:0] rand_mat();
      logic [N*N*DW-1:0] m;
      for (int k = 0; k < N*N; k++) m[k*DW +: DW] = DW'($urandom);
      return m;
   endfunction

   // Monitor: push expectations on accept, pop and compare on output handshake
   always @(negedge clk) begin
      if (reset) begin
         prev_ov = 1'b0;
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(mm_model(bus.a_mat, bus.b_mat, bus.signed_mode, AW, SAT_ON));
            acc_log.push_back(cyc);
            $display("accept at cycle %0d signed=%0b", cyc + 1, bus.signed_mode);
         end
         if (bus.out_valid && !prev_ov && acc_log.size() > 0)
            check("latency", CW'(cyc - acc_log[acc_log.size()-1] - 1), CW'(3*N - 1));
         if (bus.out_valid && bus.out_ready) begin
            hs_log.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_out", CW'(1), CW'(0));
            end else begin
               check("c_mat", bus.c_mat, exp_q.pop_front());
            end
            n_out++;
            $display("result %0d: C00=%0h C33=%0h", n_out, bus.c_mat[AW-1:0], bus.c_mat[CW-1 -: AW]);
         end
         prev_ov = bus.out_valid;
      end
   end

   task automatic start_job(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b, input logic s);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      bus.a_mat = a; bus.b_mat = b; bus.signed_mode = s; bus.in_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin got = 1'b1; break; end
      end
      if (!got) check("timeout_accept", CW'(0), CW'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a_mat = rand_mat(); bus.b_mat = rand_mat(); bus.signed_mode = ~s;
   endtask

   task automatic wait_out(input int target);
      bit got;
      got = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(posedge clk);
         if (n_out >= target) begin got = 1'b1; break; end
      end
      if (!got) check("timeout_out", CW'(n_out), CW'(target));
      #1;
   endtask

   logic [N*N*DW-1:0] a_id, b_seq, a_r, b_r;
   logic [CW-1:0]     e;
   int                base;
   bit                got;

   initial begin
      cyc = 0; n_checks = 0; n_errors = 0; n_out = 0; prev_ov = 1'b0;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.signed_mode = 1'b0; bus.a_mat = '0; bus.b_mat = '0; bus.out_ready = 1'b1;
      bus16.in_valid = 1'b0; bus16.signed_mode = 1'b0; bus16.a_mat = '0; bus16.b_mat = '0; bus16.out_ready = 1'b1;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            a_id[(i*N+j)*DW +: DW]  = (i == j) ? DW'(1) : DW'(0);
            b_seq[(i*N+j)*DW +: DW] = DW'(4*i + j + 1);
         end

      // Reset state
      repeat (3) @(posedge clk); #1;
      check("rst_in_ready", CW'(bus.in_ready), CW'(0));
      check("rst_out_valid", CW'(bus.out_valid), CW'(0));
      check("rst_c_mat", bus.c_mat, CW'(0));
      check("rst_ovf", CW'(bus.ovf), CW'(0));
      reset = 1'b0; #1;
      check("idle_in_ready", CW'(bus.in_ready), CW'(1));

      // Identity x sequence, out_ready already high: DONE lasts one cycle
      start_job(a_id, b_seq, 1'b0);
      wait_out(1);
      check("done_1cyc", CW'(bus.out_valid), CW'(0));
      check("ident_c00", CW'(bus.c_mat[AW-1:0]), CW'(1));
      check("ident_c33", CW'(bus.c_mat[CW-1 -: AW]), CW'(16));

      // Signed extremes
      start_job(fill_mat(8'h80), fill_mat(8'h80), 1'b1);
      wait_out(2);
      check("neg128_c00", CW'(bus.c_mat[AW-1:0]), CW'(20'h10000));
      start_job(fill_mat(8'hFF), fill_mat(8'h05), 1'b1);
      wait_out(3);
      check("neg20_c00", CW'(bus.c_mat[AW-1:0]), CW'(20'hFFFEC));

      // Output backpressure with in_valid pulses during COMPUTE and DONE
      bus.out_ready = 1'b0;
      a_r = rand_mat(); b_r = rand_mat();
      start_job(a_r, b_r, 1'b0);
      repeat (3) @(posedge clk); #1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.out_valid) begin got = 1'b1; break; end
      end
      if (!got) check("timeout_done", CW'(0), CW'(1));
      e = (exp_q.size() > 0) ? exp_q[0] : '0;
      check("bp_queue", CW'(exp_q.size()), CW'(1));
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         bus.in_valid = (c == 1);
         @(negedge clk);
         check("bp_out_valid", CW'(bus.out_valid), CW'(1));
         check("bp_in_ready", CW'(bus.in_ready), CW'(0));
         check("bp_c_mat", bus.c_mat, e);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      wait_out(4);
      check("bp_released", CW'(bus.out_valid), CW'(0));
      check("idle_retains", bus.c_mat, e);
      check("pulse_ignored", CW'(exp_q.size()), CW'(0));

      // Reset in the middle of COMPUTE
      start_job(a_id, b_seq, 1'b0);
      repeat (5) @(posedge clk); #2;
      reset = 1'b1; #1;
      check("abort_out_valid", CW'(bus.out_valid), CW'(0));
      check("abort_c_mat", bus.c_mat, CW'(0));
      check("abort_in_ready", CW'(bus.in_ready), CW'(0));
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0; #1;
      check("abort_idle", CW'(bus.in_ready), CW'(1));
      base = n_out;
      repeat (15) @(posedge clk);
      check("abort_no_out", CW'(n_out), CW'(base));
      start_job(a_id, b_seq, 1'b0);
      wait_out(base + 1);
      check("after_abort_c", CW'(bus.c_mat[5*AW +: AW]), CW'(6));

      // Narrow accumulator: all 255 unsigned
      @(posedge clk); #1;
      bus16.a_mat = fill_mat(8'hFF); bus16.b_mat = fill_mat(8'hFF); bus16.in_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (bus16.in_ready) begin got = 1'b1; break; end
      end
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus16.out_valid) begin got = got & 1'b1; break; end
         if (t == 49) got = 1'b0;
      end
      if (!got) check("timeout_acc16", CW'(0), CW'(1));
      check("acc16_c_mat", CW'(bus16.c_mat), mm_model(fill_mat(8'hFF), fill_mat(8'hFF), 1'b0, 16, SAT_ON));
      check("acc16_c00", CW'(bus16.c_mat[15:0]), SAT_ON ? CW'(16'hFFFF) : CW'(16'hF804));
      check("acc16_ovf", CW'(bus16.ovf), CW'(SAT_ON));
      $display("acc16 job: C00=%0h ovf=%0b", bus16.c_mat[15:0], bus16.ovf);

      // Back-to-back jobs with in_valid and out_ready held high
      base = n_out;
      @(posedge clk); #1;
      bus.a_mat = rand_mat(); bus.b_mat = rand_mat(); bus.signed_mode = 1'b0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin got = 1'b1; break; end
      end
      @(posedge clk); #1;
      bus.a_mat = rand_mat(); bus.b_mat = rand_mat(); bus.signed_mode = 1'b1;
      for (int t = 0; t < 60; t++) begin
         @(posedge clk); #1;
         if (acc_log.size() > 0 && acc_log[acc_log.size()-1] >= hs_log[hs_log.size()-1] && n_out > base) break;
      end
      bus.in_valid = 1'b0;
      if (!got) check("timeout_b2b", CW'(0), CW'(1));
      wait_out(base + 2);
      check("b2b_count", CW'(n_out - base), CW'(2));
      check("b2b_gap", CW'(acc_log[acc_log.size()-1] - hs_log[hs_log.size()-2]), CW'(1));
      check("b2b_queue", CW'(exp_q.size()), CW'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
